// File: rtl/forwarding_hazard_unit_if.sv
// Decode-side fields in, EX operand-mux selects and load-use stall out.
// master drives the ID/EX fields; slave is the forwarding/hazard unit.
interface forwarding_hazard_unit_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] ID_Rs;
    logic [REG_ADDR_W-1:0] ID_Rt;
    logic                  ID_UsesRs;
    logic                  ID_UsesRt;
    logic                  ID_RegWrite;
    logic                  ID_MemRead;
    logic                  Flush;
    logic [REG_ADDR_W-1:0] EX_DestReg;
    logic [1:0]            ForwardA;
    logic [1:0]            ForwardB;
    logic                  Stall;
    logic [CNT_W-1:0]      StallCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead,
        output Flush, EX_DestReg,
        input  ForwardA, ForwardB, Stall, StallCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead,
        input  Flush, EX_DestReg,
        output ForwardA, ForwardB, Stall, StallCount
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Purpose: EX-stage ForwardA/ForwardB selects and load-use stall from internally tracked EX/MEM/WB tags.
// Latency: Stall combinational from ID fields; forward codes valid one edge after the consumer leaves ID.
// Backpressure: Stall holds PC and IF/ID and injects one bubble into EX; Flush squashes and suppresses Stall.
module forwarding_hazard_unit #(
    parameter int REG_ADDR_W         = 3,
    parameter int CNT_W              = 16,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    forwarding_hazard_unit_if.slave  bus
);
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
        logic                  reg_write;
        logic                  mem_read;
    } ex_tag_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } mem_tag_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
    } wb_tag_t;

    ex_tag_t          ex_tag_q,  ex_tag_d;
    mem_tag_t         mem_tag_q, mem_tag_d;
    wb_tag_t          wb_tag_q,  wb_tag_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       stall;
    logic       dest_live;
    logic       hit_rs;
    logic       hit_rt;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] r);
        return (ZERO_REG_HARDWIRED != 0) && (r == '0);
    endfunction

    // Loads in MEM are excluded: their data only exists once they reach WB.
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_ADDR_W-1:0] src,
                                           input mem_tag_t m, input wb_tag_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (uses && !is_zero_reg(src)) begin
            if (m.reg_write && !m.mem_read && m.dest == src) begin
                sel = 2'b10;
            end else if (w.reg_write && w.dest == src) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        dest_live = !is_zero_reg(bus.EX_DestReg);
        hit_rs    = bus.ID_UsesRs && (bus.ID_Rs == bus.EX_DestReg);
        hit_rt    = bus.ID_UsesRt && (bus.ID_Rt == bus.EX_DestReg);
        stall     = ex_tag_q.mem_read && ex_tag_q.reg_write && dest_live
                    && (hit_rs || hit_rt) && !bus.Flush;
        fwd_a     = fwd_sel(ex_tag_q.uses_rs, ex_tag_q.rs, mem_tag_q, wb_tag_q);
        fwd_b     = fwd_sel(ex_tag_q.uses_rt, ex_tag_q.rt, mem_tag_q, wb_tag_q);
    end

    always_comb begin
        wb_tag_d           = wb_tag_q;
        mem_tag_d          = mem_tag_q;
        ex_tag_d           = ex_tag_q;
        stall_cnt_d        = stall_cnt_q;

        wb_tag_d.dest      = mem_tag_q.dest;
        wb_tag_d.reg_write = mem_tag_q.reg_write;

        mem_tag_d.dest      = bus.EX_DestReg;
        mem_tag_d.reg_write = ex_tag_q.reg_write;
        mem_tag_d.mem_read  = ex_tag_q.mem_read;

        if (stall || bus.Flush) begin
            ex_tag_d = '0;
        end else begin
            ex_tag_d.rs        = bus.ID_Rs;
            ex_tag_d.rt        = bus.ID_Rt;
            ex_tag_d.uses_rs   = bus.ID_UsesRs;
            ex_tag_d.uses_rt   = bus.ID_UsesRt;
            ex_tag_d.reg_write = bus.ID_RegWrite;
            ex_tag_d.mem_read  = bus.ID_MemRead;
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_tag_q    <= '0;
            mem_tag_q   <= '0;
            wb_tag_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_tag_q    <= ex_tag_d;
            mem_tag_q   <= mem_tag_d;
            wb_tag_q    <= wb_tag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ForwardA   = fwd_a;
    assign bus.ForwardB   = fwd_b;
    assign bus.Stall      = stall;
    assign bus.StallCount = stall_cnt_q;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Random instruction stream against an instruction-level pipeline model; a CNT_W=2 copy checks counter saturation.
module tb_forwarding_hazard_unit;
    typedef struct {
        int rs;
        int rt;
        bit uses_rs;
        bit uses_rt;
        bit rw;
        bit mr;
        int dest;
    } ins_t;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    forwarding_hazard_unit_if #(.REG_ADDR_W(3), .CNT_W(16)) bus ();
    forwarding_hazard_unit_if #(.REG_ADDR_W(3), .CNT_W(2))  bus_sat ();

    assign bus_sat.ID_Rs       = bus.ID_Rs;
    assign bus_sat.ID_Rt       = bus.ID_Rt;
    assign bus_sat.ID_UsesRs   = bus.ID_UsesRs;
    assign bus_sat.ID_UsesRt   = bus.ID_UsesRt;
    assign bus_sat.ID_RegWrite = bus.ID_RegWrite;
    assign bus_sat.ID_MemRead  = bus.ID_MemRead;
    assign bus_sat.Flush       = bus.Flush;
    assign bus_sat.EX_DestReg  = bus.EX_DestReg;

    forwarding_hazard_unit #(.REG_ADDR_W(3), .CNT_W(16), .ZERO_REG_HARDWIRED(1)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    forwarding_hazard_unit #(.REG_ADDR_W(3), .CNT_W(2), .ZERO_REG_HARDWIRED(1)) dut_sat (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_sat.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    ins_t ex_m, mem_m, wb_m, id_m;
    int   stall_total;
    bit   held;
    bit   flush;
    bit   es;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ins_t bubble();
        ins_t b;
        b.rs = 0; b.rt = 0; b.uses_rs = 0; b.uses_rt = 0; b.rw = 0; b.mr = 0; b.dest = 0;
        return b;
    endfunction

    // Small register range most of the time so hazards are frequent.
    function automatic int rand_reg();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
    endfunction

    function automatic ins_t rand_ins();
        ins_t r;
        r.rs      = rand_reg();
        r.rt      = rand_reg();
        r.uses_rs = ($urandom_range(0, 4) != 0);
        r.uses_rt = ($urandom_range(0, 2) != 0);
        r.mr      = ($urandom_range(0, 2) == 0);
        r.rw      = r.mr ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) != 0);
        r.dest    = rand_reg();
        return r;
    endfunction

    // Newest producer wins; a load still in MEM has no data to offer yet.
    function automatic int exp_fwd(bit uses, int src);
        if (!uses || src == 0) return 0;
        if (mem_m.rw && !mem_m.mr && mem_m.dest == src) return 2;
        if (wb_m.rw && wb_m.dest == src) return 1;
        return 0;
    endfunction

    function automatic bit exp_stall(bit fl);
        if (fl || !(ex_m.mr && ex_m.rw) || ex_m.dest == 0) return 0;
        return (id_m.uses_rs && id_m.rs == ex_m.dest) || (id_m.uses_rt && id_m.rt == ex_m.dest);
    endfunction

    task automatic drive(input bit fl);
        bus.ID_Rs       = 3'(id_m.rs);
        bus.ID_Rt       = 3'(id_m.rt);
        bus.ID_UsesRs   = id_m.uses_rs;
        bus.ID_UsesRt   = id_m.uses_rt;
        bus.ID_RegWrite = id_m.rw;
        bus.ID_MemRead  = id_m.mr;
        bus.Flush       = fl;
        bus.EX_DestReg  = 3'(ex_m.dest);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fwdA"}, 32'(bus.ForwardA), 0);
        check({tag, "_fwdB"}, 32'(bus.ForwardB), 0);
        check({tag, "_stall"}, 32'(bus.Stall), 0);
        check({tag, "_cnt"}, 32'(bus.StallCount), 0);
        check({tag, "_cnt_sat"}, 32'(bus_sat.StallCount), 0);
    endtask

    task automatic model_clear();
        ex_m = bubble(); mem_m = bubble(); wb_m = bubble();
        stall_total = 0;
        held = 0;
    endtask

    initial begin
        Rst_n = 1'b0;
        model_clear();
        id_m = rand_ins();
        ex_m.dest = rand_reg();
        drive($urandom_range(0, 1));
        #2;
        check_reset_outputs("reset0");
        repeat (3) begin
            @(negedge Clk);
            id_m = rand_ins();
            drive($urandom_range(0, 1));
            #1;
            check_reset_outputs("reset_hold");
        end
        ex_m = bubble();

        @(negedge Clk);
        Rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc != 0) @(negedge Clk);
            if ($urandom_range(0, 149) == 0) begin
                Rst_n = 1'b0;
                #1;
                check_reset_outputs("midreset");
                model_clear();
                #2;
                Rst_n = 1'b1;
            end
            flush = ($urandom_range(0, 9) == 0);
            if (!held) id_m = rand_ins();
            drive(flush);
            #1;
            es = exp_stall(flush);
            check("stall", 32'(bus.Stall), 32'(es));
            check("fwdA", 32'(bus.ForwardA), exp_fwd(ex_m.uses_rs, ex_m.rs));
            check("fwdB", 32'(bus.ForwardB), exp_fwd(ex_m.uses_rt, ex_m.rt));
            check("stall_count", 32'(bus.StallCount), stall_total);
            check("stall_count_sat", 32'(bus_sat.StallCount), (stall_total > 3) ? 3 : stall_total);

            @(posedge Clk);
            wb_m  = mem_m;
            mem_m = ex_m;
            ex_m  = (es || flush) ? bubble() : id_m;
            if (es) stall_total++;
            held = es;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
